// File: rtl/nexthop_route_table.sv
`default_nettype none
// ============================================================================
// Module   : nexthop_route_table
// Brief    : Per-channel next-hop route lock (IDLE / HOLD / RELEASE) with
//            registered outputs. Optional per-channel stall watchdog is built
//            when the macro NHR_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module nexthop_route_table #(
    parameter int                NUM_CH       = 5,
    parameter int                ADDR_W       = 3,
    parameter logic [ADDR_W-1:0] DEFAULT_ADDR = 3'b011,
    parameter int                TIMEOUT      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ib_empty_i,
    input  logic [NUM_CH-1:0]        pt_almost_done_i,
    input  logic [NUM_CH-1:0]        nhr_write_i,
    input  logic [NUM_CH*ADDR_W-1:0] nhr_address_i,
    input  logic [NUM_CH-1:0]        flit_sent_i,
    output logic [NUM_CH*ADDR_W-1:0] nhr_address_o,
    output logic [NUM_CH-1:0]        nhr_valid_o,
    output logic [NUM_CH-1:0]        nhr_timeout_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_HOLD    = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

`ifdef NHR_TIMEOUT_EN
    localparam logic [7:0] c_STALL_LAST = 8'(TIMEOUT - 1);
`else
    // Watchdog inputs have no function in this build.
    logic w_unused_wdog;
    assign w_unused_wdog = ^{flit_sent_i, 8'(TIMEOUT)};
`endif

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [1:0]        r_state;
            logic [ADDR_W-1:0] r_addr;
            logic              r_valid;
            logic              w_stall_expired;

`ifdef NHR_TIMEOUT_EN
            logic [7:0] r_stall;
            logic       r_timeout;

            assign w_stall_expired = !flit_sent_i[c] && (r_stall == c_STALL_LAST);

            // Counter only runs while the route is locked; any flit restarts it.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_stall   <= 8'd0;
                    r_timeout <= 1'b0;
                end else begin
                    r_timeout <= (r_state == c_HOLD) && !pt_almost_done_i[c] &&
                                 !ib_empty_i[c] && w_stall_expired;
                    if ((r_state != c_HOLD) || flit_sent_i[c])
                        r_stall <= 8'd0;
                    else
                        r_stall <= r_stall + 8'd1;
                end
            end

            assign nhr_timeout_o[c] = r_timeout;
`else
            assign w_stall_expired  = 1'b0;
            assign nhr_timeout_o[c] = 1'b0;
`endif

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= c_IDLE;
                    r_addr  <= DEFAULT_ADDR;
                    r_valid <= 1'b0;
                end else begin
                    case (r_state)
                        c_IDLE: begin
                            if (nhr_write_i[c] && !ib_empty_i[c]) begin
                                r_state <= c_HOLD;
                                r_addr  <= nhr_address_i[c*ADDR_W +: ADDR_W];
                                r_valid <= 1'b1;
                            end else begin
                                r_addr  <= DEFAULT_ADDR;
                                r_valid <= 1'b0;
                            end
                        end
                        c_HOLD: begin
                            // Packet end wins over an empty buffer, both over the watchdog.
                            if (pt_almost_done_i[c]) begin
                                r_state <= c_RELEASE;
                                r_valid <= 1'b0;
                            end else if (ib_empty_i[c] || w_stall_expired) begin
                                r_state <= c_IDLE;
                                r_addr  <= DEFAULT_ADDR;
                                r_valid <= 1'b0;
                            end
                        end
                        default: begin
                            r_state <= c_IDLE;
                            r_addr  <= DEFAULT_ADDR;
                            r_valid <= 1'b0;
                        end
                    endcase
                end
            end

            assign nhr_address_o[c*ADDR_W +: ADDR_W] = r_addr;
            assign nhr_valid_o[c]                    = r_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_nexthop_route_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_nexthop_route_table
// Brief    : Directed plus randomized bench for nexthop_route_table, checked
//            against a behavioural per-channel route model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nexthop_route_table;

    localparam int               NUM_CH  = 5;
    localparam int               ADDR_W  = 3;
    localparam logic [ADDR_W-1:0] DEF    = 3'b011;
    localparam int               TIMEOUT = 16;

    logic                     clk;
    logic                     reset;
    logic [NUM_CH-1:0]        ib_empty_i;
    logic [NUM_CH-1:0]        pt_almost_done_i;
    logic [NUM_CH-1:0]        nhr_write_i;
    logic [NUM_CH*ADDR_W-1:0] nhr_address_i;
    logic [NUM_CH-1:0]        flit_sent_i;
    logic [NUM_CH*ADDR_W-1:0] nhr_address_o;
    logic [NUM_CH-1:0]        nhr_valid_o;
    logic [NUM_CH-1:0]        nhr_timeout_o;

    nexthop_route_table #(
        .NUM_CH       (NUM_CH),
        .ADDR_W       (ADDR_W),
        .DEFAULT_ADDR (DEF),
        .TIMEOUT      (TIMEOUT)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .ib_empty_i       (ib_empty_i),
        .pt_almost_done_i (pt_almost_done_i),
        .nhr_write_i      (nhr_write_i),
        .nhr_address_i    (nhr_address_i),
        .flit_sent_i      (flit_sent_i),
        .nhr_address_o    (nhr_address_o),
        .nhr_valid_o      (nhr_valid_o),
        .nhr_timeout_o    (nhr_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: 0 = no route, 1 = route locked, 2 = route draining (one cycle).
    int                m_mode  [NUM_CH];
    logic [ADDR_W-1:0] m_route [NUM_CH];
    int                m_stall [NUM_CH];
    bit                m_pulse [NUM_CH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c]  = 0;
            m_route[c] = DEF;
            m_stall[c] = 0;
            m_pulse[c] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            m_pulse[c] = 1'b0;
            if (m_mode[c] == 0) begin
                if (nhr_write_i[c] && !ib_empty_i[c]) begin
                    m_mode[c]  = 1;
                    m_route[c] = nhr_address_i[c*ADDR_W +: ADDR_W];
                    m_stall[c] = 0;
                end
            end else if (m_mode[c] == 1) begin
                if (pt_almost_done_i[c]) m_mode[c] = 2;
                else if (ib_empty_i[c])  m_mode[c] = 0;
`ifdef NHR_TIMEOUT_EN
                else if (!flit_sent_i[c] && m_stall[c] == TIMEOUT - 1) begin
                    m_mode[c]  = 0;
                    m_pulse[c] = 1'b1;
                end else
                    m_stall[c] = flit_sent_i[c] ? 0 : m_stall[c] + 1;
`endif
            end else begin
                m_mode[c] = 0;
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        logic [NUM_CH*ADDR_W-1:0] e_addr;
        logic [NUM_CH-1:0]        e_valid;
        logic [NUM_CH-1:0]        e_to;
        for (int c = 0; c < NUM_CH; c++) begin
            e_addr[c*ADDR_W +: ADDR_W] = (m_mode[c] != 0) ? m_route[c] : DEF;
            e_valid[c] = (m_mode[c] == 1);
            e_to[c]    = m_pulse[c];
        end
        check_val({tag, " addr"},    32'(nhr_address_o), 32'(e_addr));
        check_val({tag, " valid"},   32'(nhr_valid_o),   32'(e_valid));
        check_val({tag, " timeout"}, 32'(nhr_timeout_o), 32'(e_to));
    endtask

    // Inputs are applied 1ns after an edge, so the model sees them before the next edge.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic clear_inputs();
        ib_empty_i       = '0;
        pt_almost_done_i = '0;
        nhr_write_i      = '0;
        nhr_address_i    = '0;
        flit_sent_i      = '0;
    endtask

    task automatic rand_inputs(input int p_empty, input int p_done, input int p_wr, input int p_flit);
        for (int c = 0; c < NUM_CH; c++) begin
            ib_empty_i[c]       = ($urandom_range(99) < p_empty);
            pt_almost_done_i[c] = ($urandom_range(99) < p_done);
            nhr_write_i[c]      = ($urandom_range(99) < p_wr);
            flit_sent_i[c]      = ($urandom_range(99) < p_flit);
            nhr_address_i[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        end
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #1 reset = 1'b1;
    endtask

    initial begin
        int pulses;
        int pulse_at;

        clear_inputs();
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst addr",  32'(nhr_address_o), 32'({NUM_CH{DEF}}));
        check_val("rst valid", 32'(nhr_valid_o),   32'd0);
        check_val("rst to",    32'(nhr_timeout_o), 32'd0);
        reset = 1'b1;

        // Write on ch2 is locked; a second write during the lock is ignored.
        nhr_write_i[2] = 1'b1;
        nhr_address_i[2*ADDR_W +: ADDR_W] = 3'b101;
        cycle("ch2 wr");
        check_val("ch2 lock addr",  32'(nhr_address_o[2*ADDR_W +: ADDR_W]), 32'(3'b101));
        check_val("ch2 lock valid", 32'(nhr_valid_o[2]), 32'd1);
        nhr_address_i[2*ADDR_W +: ADDR_W] = 3'b001;
        cycle("ch2 rewr");
        check_val("ch2 hold addr", 32'(nhr_address_o[2*ADDR_W +: ADDR_W]), 32'(3'b101));
        clear_inputs();

        // ch0: packet end and empty together -> one release cycle.
        nhr_write_i[0] = 1'b1;
        nhr_address_i[0 +: ADDR_W] = 3'b110;
        cycle("ch0 wr");
        clear_inputs();
        pt_almost_done_i[0] = 1'b1;
        ib_empty_i[0]       = 1'b1;
        cycle("ch0 rel");
        check_val("ch0 rel valid", 32'(nhr_valid_o[0]), 32'd0);
        check_val("ch0 rel addr",  32'(nhr_address_o[0 +: ADDR_W]), 32'(3'b110));
        clear_inputs();
        cycle("ch0 idle");
        check_val("ch0 idle addr", 32'(nhr_address_o[0 +: ADDR_W]), 32'(DEF));

        // ch4: write with empty buffer is dropped.
        nhr_write_i[4]  = 1'b1;
        ib_empty_i[4]   = 1'b1;
        nhr_address_i[4*ADDR_W +: ADDR_W] = 3'b111;
        cycle("ch4 empty wr");
        check_val("ch4 addr",  32'(nhr_address_o[4*ADDR_W +: ADDR_W]), 32'(DEF));
        check_val("ch4 valid", 32'(nhr_valid_o[4]), 32'd0);
        clear_inputs();

        // ch1: reset between edges clears the lock without a clock.
        nhr_write_i[1] = 1'b1;
        nhr_address_i[1*ADDR_W +: ADDR_W] = 3'b010;
        cycle("ch1 wr");
        clear_inputs();
        #2 reset = 1'b0;
        #1;
        check_val("ch1 arst addr",  32'(nhr_address_o[1*ADDR_W +: ADDR_W]), 32'(DEF));
        check_val("ch1 arst valid", 32'(nhr_valid_o[1]), 32'd0);
        model_reset();
        compare_all("arst all");
        @(posedge clk);
        #1 reset = 1'b1;
        // First write is taken on the first edge after release.
        nhr_write_i[1] = 1'b1;
        nhr_address_i[1*ADDR_W +: ADDR_W] = 3'b100;
        cycle("ch1 post rst");
        check_val("ch1 first wr", 32'(nhr_address_o[1*ADDR_W +: ADDR_W]), 32'(3'b100));
        clear_inputs();
        reset = 1'b0;
        model_reset();
        #1 reset = 1'b1;

        // ch3 watchdog: flit on the 10th cycle restarts the count.
        nhr_write_i[3] = 1'b1;
        nhr_address_i[3*ADDR_W +: ADDR_W] = 3'b110;
        cycle("ch3 wr");
        clear_inputs();
        repeat (9) cycle("ch3 stall");
        flit_sent_i[3] = 1'b1;
        cycle("ch3 flit");
        flit_sent_i[3] = 1'b0;
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle("ch3 wd");
            if (nhr_timeout_o[3]) begin
                pulses++;
                pulse_at = i;
            end
        end
`ifdef NHR_TIMEOUT_EN
        check_val("ch3 pulses",   32'(pulses),   32'd1);
        check_val("ch3 pulse at", 32'(pulse_at), 32'd16);
        check_val("ch3 released", 32'(nhr_valid_o[3]), 32'd0);
`else
        check_val("ch3 pulses", 32'(pulses), 32'd0);
        check_val("ch3 held",   32'(nhr_valid_o[3]), 32'd1);
`endif
        clear_inputs();

        // Randomized traffic: mixed, then long stalls to reach the watchdog.
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(25, 12, 50, 50);
            if (i % 250 == 249) async_reset_pulse();
            else                cycle("rnd a");
        end
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(3, 3, 60, 5);
            cycle("rnd b");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/nexthop_route_table.md
NEXTHOP_ROUTE_TABLE -- requirements
Module: nexthop_route_table

Interface
REQ-001 Parameter NUM_CH, default 5: number of independent input channels, each with one next-hop entry.
REQ-002 Parameter ADDR_W, default 3: width of one next-hop address.
REQ-003 Parameter DEFAULT_ADDR, default 3'b011: address driven when an entry is not routed. It is ADDR_W bits wide.
REQ-004 Parameter TIMEOUT, default 16: stall-watchdog limit in cycles, range 2..255. It is used only when NHR_TIMEOUT_EN is defined.
REQ-005 Port clk, input, 1 bit: the single clock. All flops are rising-edge triggered.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port ib_empty_i, input, NUM_CH bits: per-channel input buffer empty flag.
REQ-008 Port pt_almost_done_i, input, NUM_CH bits: per-channel packet-transfer-almost-done flag.
REQ-009 Port nhr_write_i, input, NUM_CH bits: per-channel route write strobe.
REQ-010 Port nhr_address_i, input, NUM_CH*ADDR_W bits: per-channel route address. Channel c occupies bits [c*ADDR_W +: ADDR_W].
REQ-011 Port flit_sent_i, input, NUM_CH bits: per-channel flit-forwarded pulse.
REQ-012 Port nhr_address_o, output, NUM_CH*ADDR_W bits: per-channel registered next-hop address, packed the same way as nhr_address_i.
REQ-013 Port nhr_valid_o, output, NUM_CH bits: per-channel flag indicating the route is locked and valid.
REQ-014 Port nhr_timeout_o, output, NUM_CH bits: per-channel one-cycle watchdog-release pulse.

Function
REQ-015 Each channel shall run an independent three-state FSM:
- IDLE
- HOLD
- RELEASE
All outputs shall be registered.
REQ-016 IDLE: the channel shall drive nhr_address_o = DEFAULT_ADDR and nhr_valid_o = 0.
REQ-017 IDLE to HOLD: when nhr_write_i = 1 and ib_empty_i = 0, the channel shall latch nhr_address_i. The latched address shall appear on nhr_address_o with nhr_valid_o = 1 on the next cycle (1-cycle latency).
REQ-018 IDLE with nhr_write_i = 1 and ib_empty_i = 1: the write shall be ignored and the channel stays in IDLE.
REQ-019 HOLD: the latched address shall be held, and any nhr_write_i shall be ignored (route lock for the whole packet).
REQ-020 HOLD to RELEASE: when pt_almost_done_i = 1, the channel moves to RELEASE. The address stays latched and nhr_valid_o = 0 for exactly one cycle.
REQ-021 HOLD to IDLE: when ib_empty_i = 1 and pt_almost_done_i = 0, the channel returns to IDLE. The address becomes DEFAULT_ADDR next cycle.
REQ-022 HOLD with pt_almost_done_i = 1 and ib_empty_i = 1 in the same cycle: pt_almost_done_i has priority, so the channel goes to RELEASE.
REQ-023 RELEASE: the channel shall return to IDLE unconditionally after one cycle. A write in RELEASE shall be ignored and is not queued.
REQ-024 Channels shall not interact. Simultaneous events on different channels shall be handled independently in the same cycle.

Reset
REQ-025 While reset = 0, every channel shall asynchronously enter IDLE. Outputs shall be:
- nhr_address_o = DEFAULT_ADDR
- nhr_valid_o = 0
- nhr_timeout_o = 0
- watchdog counters = 0
REQ-026 Reset asserted mid-packet (in HOLD or RELEASE) shall discard the latched route immediately, without waiting for a clock edge.
REQ-027 Deassertion of reset shall take effect at the next rising edge of clk. The first write shall be accepted on that edge.

Configuration
REQ-028 When macro NHR_TIMEOUT_EN is defined, each channel shall contain an 8-bit stall counter. Its behaviour in HOLD:
- it clears on entry to HOLD and on every cycle with flit_sent_i = 1;
- it increments on every other cycle;
- on reaching TIMEOUT-1 with no flit sent, the channel goes to IDLE and pulses nhr_timeout_o for one cycle.
pt_almost_done_i and ib_empty_i shall take priority over the timeout.
REQ-029 When NHR_TIMEOUT_EN is undefined, no counter shall exist, nhr_timeout_o shall be tied to 0, and HOLD shall persist indefinitely.

Verification
REQ-030 Reset release, NUM_CH = 5: all nhr_address_o fields = 3'b011; nhr_valid_o = 5'b0; nhr_timeout_o = 5'b0.
REQ-031 Channel 2: write addr 3'b101 with ib_empty_i = 0 -> next cycle field 2 = 3'b101 and valid[2] = 1. A second write of 3'b001 during HOLD -> field stays 3'b101.
REQ-032 Channel 0 in HOLD: assert pt_almost_done_i[0] and ib_empty_i[0] together -> one RELEASE cycle (valid[0] = 0, addr unchanged), then 3'b011.
REQ-033 Channel 4 in IDLE: write with ib_empty_i[4] = 1 -> address stays 3'b011 and valid[4] = 0.
REQ-034 Assert reset low mid-HOLD on channel 1 between clock edges -> addr 3'b011 and valid 0 immediately, without waiting for a clock edge.
REQ-035 With NHR_TIMEOUT_EN defined and TIMEOUT = 16: channel 3 in HOLD, flit_sent_i[3] = 0 for 16 cycles -> timeout[3] pulses once and channel 3 returns to IDLE. A flit on cycle 10 shall restart the count.
